mdu_iterative: RTL and testbench

- Multi-cycle RV32M multiply/divide unit that answers the execute stage's issue requests: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU.
- Sits beside the single-cycle ALU in EX. EX issues operands plus an M-op code and stalls the pipeline until the unit returns a registered result.
- Radix-2 shift-add multiply and restoring divide. Divide-by-zero and signed overflow are special cases with a short path.

---
 rtl/mdu_pkg.sv | 38 +++
 rtl/mdu_operand_prep.sv | 79 +++++++
 rtl/mdu_iterative.sv | 206 ++++++++++++++++++++
 tb/tb_mdu_iterative.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// Purpose: shared types and constants for the iterative RV32M multiply/divide unit.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mdu_pkg;

  // funct3 encodings of the M extension
  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } mdu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } mdu_state_e;

  localparam logic [31:0] INT_MIN  = 32'h8000_0000;
  localparam logic [31:0] ALL_ONES = 32'hFFFF_FFFF;

  // funct3[2] separates the divide family from the multiply family
  function automatic logic is_div_op(input mdu_op_e op);
    return op[2];
  endfunction

  // DIV/DIVU/REM/REMU: funct3[1] selects remainder over quotient
  function automatic logic is_rem_op(input mdu_op_e op);
    return op[2] & op[1];
  endfunction

endpackage

// File: rtl/mdu_operand_prep.sv
// Purpose: converts issue operands to unsigned magnitudes, derives the result-sign
//          flag and detects the divide special cases (b==0, INT_MIN / -1).
// Latency: combinational. Backpressure: none, sampled by the top only on accept.
// Ports: op (M-op), a/b (raw rs1/rs2) -> a_mag/b_mag (magnitudes), neg_res
//        (negate in FIX), special (skip CALC), special_res (short-path result).
module mdu_operand_prep
  import mdu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  mdu_op_e           op,
  input  logic [XLEN-1:0]   a,
  input  logic [XLEN-1:0]   b,
  output logic [XLEN-1:0]   a_mag,
  output logic [XLEN-1:0]   b_mag,
  output logic              neg_res,
  output logic              special,
  output logic [XLEN-1:0]   special_res
);

  logic            a_neg;
  logic            b_neg;
  logic [XLEN-1:0] a_abs;
  logic [XLEN-1:0] b_abs;

  assign a_neg = a[XLEN-1];
  assign b_neg = b[XLEN-1];
  // INT_MIN maps onto itself, which is its correct unsigned magnitude
  assign a_abs = a_neg ? -a : a;
  assign b_abs = b_neg ? -b : b;

  always_comb begin
    a_mag   = a;
    b_mag   = b;
    neg_res = 1'b0;
    case (op)
      OP_MULH: begin
        a_mag   = a_abs;
        b_mag   = b_abs;
        neg_res = a_neg ^ b_neg;
      end
      OP_MULHSU: begin
        a_mag   = a_abs;
        neg_res = a_neg;
      end
      OP_DIV: begin
        a_mag   = a_abs;
        b_mag   = b_abs;
        neg_res = a_neg ^ b_neg;
      end
      OP_REM: begin
        // remainder takes the sign of the dividend
        a_mag   = a_abs;
        b_mag   = b_abs;
        neg_res = a_neg;
      end
      default: begin
        // MUL low word is sign-agnostic; MULHU/DIVU/REMU are unsigned
      end
    endcase
  end

  always_comb begin
    special     = 1'b0;
    special_res = '0;
    if (is_div_op(op)) begin
      if (b == '0) begin
        special     = 1'b1;
        special_res = is_rem_op(op) ? a : ALL_ONES[XLEN-1:0];
      end else if ((op == OP_DIV || op == OP_REM) &&
                   a == INT_MIN[XLEN-1:0] && b == ALL_ONES[XLEN-1:0]) begin
        // signed overflow: quotient saturates to INT_MIN, remainder is zero
        special     = 1'b1;
        special_res = (op == OP_REM) ? '0 : INT_MIN[XLEN-1:0];
      end
    end
  end

endmodule

// File: rtl/mdu_iterative.sv
// Purpose: iterative RV32M multiply/divide unit (radix-2 shift-add, restoring divide).
// Latency: XLEN+1 edges from accept to out_valid; 0 extra edges for special cases.
// Backpressure: in_ready high only in IDLE; in_valid while busy is ignored.
// Ports: clk, rst_n (async, active low); in_valid/in_ready/op/a/b issue handshake;
//        flush aborts work in flight; out_valid one-cycle pulse with held result.
module mdu_iterative
  import mdu_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = $clog2(XLEN)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        op,
  input  logic [XLEN-1:0]   a,
  input  logic [XLEN-1:0]   b,
  input  logic              flush,
  output logic              out_valid,
  output logic [XLEN-1:0]   result
);

  mdu_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  mdu_op_e         op_q;
  logic            neg_q;
  // acc_q/lo_q form the 2*XLEN product for multiply; for divide acc_q is the
  // partial remainder and lo_q shifts the dividend out while the quotient shifts in
  logic [XLEN-1:0] acc_q;
  logic [XLEN-1:0] lo_q;
  logic [XLEN-1:0] opnd_q;   // multiplicand or divisor
  logic [XLEN-1:0] result_q;

  mdu_op_e         op_in;
  logic [XLEN-1:0] a_mag;
  logic [XLEN-1:0] b_mag;
  logic            neg_res;
  logic            special;
  logic [XLEN-1:0] special_res;
  logic            accept;
  logic            last_iter;

  assign op_in = mdu_op_e'(op);

  mdu_operand_prep #(
    .XLEN (XLEN)
  ) u_prep (
    .op          (op_in),
    .a           (a),
    .b           (b),
    .a_mag       (a_mag),
    .b_mag       (b_mag),
    .neg_res     (neg_res),
    .special     (special),
    .special_res (special_res)
  );

  assign accept    = in_valid & in_ready & ~flush;
  assign last_iter = (cnt_q == CNT_W'(XLEN-1));

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = special ? DONE : CALC;
        end
      end
      CALC: begin
        if (flush) begin
          state_d = IDLE;
        end else if (last_iter) begin
          state_d = FIX;
        end
      end
      FIX: begin
        state_d = flush ? IDLE : DONE;
      end
      DONE: begin
        // a flush here is harmless: EX discards the pulse
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
  end

  // ---------------------------------------------------------------- iteration step
  logic [XLEN:0]   mul_sum;
  logic [XLEN:0]   div_shift;
  logic [XLEN+1:0] div_diff;
  logic            div_ok;
  logic [XLEN-1:0] acc_step;
  logic [XLEN-1:0] lo_step;
  logic            unused_div_bit;

  always_comb begin
    // multiply: conditionally add multiplicand to the high half, then shift the
    // 2*XLEN+1 bit {carry, acc, lo} right by one
    mul_sum   = {1'b0, acc_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
    // divide: bring the next dividend bit into the remainder and trial-subtract
    div_shift = {acc_q, lo_q[XLEN-1]};
    div_diff  = {1'b0, div_shift} - {2'b00, opnd_q};
    div_ok    = ~div_diff[XLEN+1];
    if (is_div_op(op_q)) begin
      // remainder stays below the divisor, so the top bit is always zero here
      acc_step = div_ok ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0];
      lo_step  = {lo_q[XLEN-2:0], div_ok};
    end else begin
      acc_step = mul_sum[XLEN:1];
      lo_step  = {mul_sum[0], lo_q[XLEN-1:1]};
    end
  end

  assign unused_div_bit = div_diff[XLEN];

  // ---------------------------------------------------------------- sign fix-up
  logic [2*XLEN-1:0] prod;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_fix;
  logic [XLEN-1:0]   rem_fix;
  logic [XLEN-1:0]   fix_res;

  always_comb begin
    prod     = {acc_q, lo_q};
    prod_fix = neg_q ? -prod : prod;
    quo_fix  = neg_q ? -lo_q : lo_q;
    rem_fix  = neg_q ? -acc_q : acc_q;
    fix_res  = '0;
    case (op_q)
      OP_MUL:                        fix_res = prod_fix[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU:  fix_res = prod_fix[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:               fix_res = quo_fix;
      OP_REM, OP_REMU:               fix_res = rem_fix;
      default:                       fix_res = '0;
    endcase
  end

  // ---------------------------------------------------------------- datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      op_q     <= OP_MUL;
      neg_q    <= 1'b0;
      acc_q    <= '0;
      lo_q     <= '0;
      opnd_q   <= '0;
      result_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            op_q  <= op_in;
            neg_q <= neg_res;
            cnt_q <= '0;
            acc_q <= '0;
            if (is_div_op(op_in)) begin
              lo_q   <= a_mag;
              opnd_q <= b_mag;
            end else begin
              lo_q   <= b_mag;
              opnd_q <= a_mag;
            end
            if (special) begin
              result_q <= special_res;
            end
          end
        end
        CALC: begin
          if (!flush) begin
            cnt_q <= cnt_q + 1'b1;
            acc_q <= acc_step;
            lo_q  <= lo_step;
          end
        end
        FIX: begin
          // result is written on the FIX -> DONE edge only
          if (!flush) begin
            result_q <= fix_res;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign result = result_q;

endmodule

// File: tb/tb_mdu_iterative.sv
// Purpose: directed self-checking bench for mdu_iterative.
// Latency: latency measured in clock edges from the accept edge to out_valid.
// Backpressure: exercises busy-time in_valid, flush and mid-op reset.
module tb_mdu_iterative;

  localparam int XLEN = 32;

  logic              clk;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [2:0]        op;
  logic [XLEN-1:0]   a;
  logic [XLEN-1:0]   b;
  logic              flush;
  logic              out_valid;
  logic [XLEN-1:0]   result;

  int checks = 0;
  int errors = 0;

  mdu_iterative #(.XLEN(XLEN)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .flush     (flush),
    .out_valid (out_valid),
    .result    (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Issue one op, measure edges from accept to out_valid, check result and pulse width.
  task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] x,
                        input logic [31:0] y, input logic [31:0] exp, input int exp_lat);
    int lat;
    @(negedge clk);
    op = o; a = x; b = y; in_valid = 1'b1;
    chk({tag, "_rdy"}, 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_res"}, result, exp);
    @(posedge clk); #1;
    chk({tag, "_pulse"}, {30'd0, out_valid, in_ready}, 32'h1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int pulses;
    rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; op = 3'd0; a = '0; b = '0;
    #12;
    chk("rst_ready",  32'(in_ready),  32'd1);
    chk("rst_valid",  32'(out_valid), 32'd0);
    chk("rst_result", result,         32'd0);
    @(negedge clk); rst_n = 1'b1;

    // multiply family
    run_op("mul_7_m3",     3'd0, 32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, 33);
    run_op("mulh_7_m3",    3'd1, 32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFFF, 33);
    run_op("mulhu_max",    3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
    run_op("mulhsu_m1",    3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33);
    run_op("mulh_min_min", 3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33);

    // divide family
    run_op("div_m20_3",    3'd4, 32'hFFFF_FFEC, 32'd3,        32'hFFFF_FFFA, 33);
    run_op("rem_m20_3",    3'd6, 32'hFFFF_FFEC, 32'd3,        32'hFFFF_FFFE, 33);
    run_op("divu_100_7",   3'd5, 32'd100,       32'd7,        32'd14,        33);
    run_op("remu_100_7",   3'd7, 32'd100,       32'd7,        32'd2,         33);
    run_op("div_7_m2",     3'd4, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 33);
    run_op("rem_7_m2",     3'd6, 32'd7,         32'hFFFF_FFFE, 32'd1,         33);
    run_op("divu_max_1",   3'd5, 32'hFFFF_FFFF, 32'd1,        32'hFFFF_FFFF, 33);
    run_op("divu_min_m1",  3'd5, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         33);

    // special cases: short path
    run_op("divu_5_0",     3'd5, 32'd5,         32'd0,        32'hFFFF_FFFF, 0);
    run_op("rem_5_0",      3'd6, 32'd5,         32'd0,        32'd5,         0);
    run_op("div_m5_0",     3'd4, 32'hFFFF_FFFB, 32'd0,        32'hFFFF_FFFF, 0);
    run_op("remu_9_0",     3'd7, 32'd9,         32'd0,        32'd9,         0);
    run_op("div_ovf",      3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0);
    run_op("rem_ovf",      3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         0);
    run_op("remu_100_7b",  3'd7, 32'd100,       32'd7,        32'd2,         33);

    // flush with in_valid in IDLE: no accept
    @(negedge clk);
    op = 3'd0; a = 32'd1; b = 32'd1; in_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    chk("idle_flush_ready", 32'(in_ready), 32'd1);
    chk("idle_flush_res",   result,        32'd2);

    // flush at CALC cycle 10 of a DIV
    @(negedge clk);
    op = 3'd4; a = 32'd1000; b = 32'd7; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("flush_busy", 32'(in_ready), 32'd0);
    pulses = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (out_valid) pulses++;
    end
    @(negedge clk); flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush_ready", 32'(in_ready),  32'd1);
    chk("flush_res",   result,         32'd2);
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid) pulses++;
    end
    chk("flush_nopulse", 32'(pulses), 32'd0);
    run_op("mul_6_7", 3'd0, 32'd6, 32'd7, 32'd42, 33);

    // asynchronous reset in the middle of CALC
    @(negedge clk);
    op = 3'd0; a = 32'd3; b = 32'd5; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk); rst_n = 1'b0;
    #1;
    chk("mrst_ready",  32'(in_ready),  32'd1);
    chk("mrst_valid",  32'(out_valid), 32'd0);
    chk("mrst_result", result,         32'd0);
    @(negedge clk); rst_n = 1'b1;
    pulses = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid) pulses++;
    end
    chk("mrst_nopulse", 32'(pulses), 32'd0);

    // in_valid held high while busy: exactly one result per accepted op
    @(negedge clk);
    op = 3'd5; a = 32'd100; b = 32'd7; in_valid = 1'b1;
    pulses = 0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #1;
      if (i == 5) chk("held_busy", 32'(in_ready), 32'd0);
      if (out_valid) begin
        pulses++;
        chk("held_res", result, 32'd14);
        in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    chk("held_pulses", 32'(pulses), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
